fft16_bf_sequencer: RTL and testbench

Control sequencer for the 16-point radix-2 decimation-in-frequency FFT. On `start` it steps one shared butterfly unit through 4 stages of 8 butterflies each. For every butterfly it issues the data-memory read addresses, the twiddle index for the signed 16x8 Q1.7 twiddle multiplier, and the matching delayed write-back addresses. It inserts a drain gap between stages so that no stage reads a word before the previous stage has written it. Output lands in bit-reversed order; reordering is outside this block.

---
 rtl/fft16_bf_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fft16_bf_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fft16_bf_sequencer.sv
// Address/twiddle sequencer for a 16-point radix-2 DIF FFT sharing one butterfly.
// Issues 4 stages x 8 butterflies with a drain gap, plus delayed bf/write strobes.
module fft16_bf_sequencer #(
    parameter int MEM_RD_LAT = 1,
    parameter int BF_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] stage,
    output logic       rd_en,
    output logic [3:0] rd_addr_a,
    output logic [3:0] rd_addr_b,
    output logic       bf_valid,
    output logic [2:0] tw_idx,
    output logic       wr_en,
    output logic [3:0] wr_addr_a,
    output logic [3:0] wr_addr_b
);
    localparam int LAT = MEM_RD_LAT + BF_LATENCY;
    localparam int CW  = $clog2(LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      k_q, k_d;
    logic [1:0]      stage_q, stage_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, done_q, rd_en_q;
    logic [3:0]      rd_a_q, rd_b_q;
    logic [2:0]      tw_q;

    logic [MEM_RD_LAT-1:0] vld_sr_q;
    logic [2:0]            tw_sr_q [MEM_RD_LAT];
    logic [LAT-1:0]        wr_sr_q;
    logic [3:0]            wa_sr_q [LAT];
    logic [3:0]            wb_sr_q [LAT];

    function automatic logic [3:0] half_of(input logic [1:0] s);
        return 4'd8 >> s;
    endfunction

    // Splitting k at bit (3-s) gives the group g and offset j; the gap bit is the b operand.
    function automatic logic [3:0] addr_a_of(input logic [2:0] k, input logic [1:0] s);
        logic [3:0] mask;
        mask = half_of(s) - 4'd1;
        return (({1'b0, k} & ~mask) << 1) | ({1'b0, k} & mask);
    endfunction

    function automatic logic [2:0] tw_of(input logic [2:0] k, input logic [1:0] s);
        logic [3:0] j;
        j = {1'b0, k} & (half_of(s) - 4'd1);
        j = j << s;
        return j[2:0];
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    stage_d = 2'd0;
                    k_d     = 3'd0;
                end
            end
            S_ISSUE: begin
                if (k_q == 3'd7) begin
                    state_d = S_DRAIN;
                    cnt_d   = CW'(LAT);
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(1)) begin
                    if (stage_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 2'd1;
                        k_d     = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                stage_d = 2'd0;
                k_d     = 3'd0;
                state_d = start ? S_ISSUE : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
            rd_en_q <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) begin
                rd_a_q <= addr_a_of(k_d, stage_d);
                rd_b_q <= addr_a_of(k_d, stage_d) + half_of(stage_d);
                tw_q   <= tw_of(k_d, stage_d);
            end
        end
    end

    // Delay lines run every cycle; reset flushes butterflies still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_q <= '0;
            wr_sr_q  <= '0;
            for (int i = 0; i < MEM_RD_LAT; i++) tw_sr_q[i] <= '0;
            for (int i = 0; i < LAT; i++) begin
                wa_sr_q[i] <= '0;
                wb_sr_q[i] <= '0;
            end
        end else begin
            vld_sr_q[0] <= rd_en_q;
            tw_sr_q[0]  <= tw_q;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
                tw_sr_q[i]  <= tw_sr_q[i-1];
            end
            wr_sr_q[0] <= rd_en_q;
            wa_sr_q[0] <= rd_a_q;
            wb_sr_q[0] <= rd_b_q;
            for (int i = 1; i < LAT; i++) begin
                wr_sr_q[i] <= wr_sr_q[i-1];
                wa_sr_q[i] <= wa_sr_q[i-1];
                wb_sr_q[i] <= wb_sr_q[i-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = stage_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign bf_valid  = vld_sr_q[MEM_RD_LAT-1];
    assign tw_idx    = tw_sr_q[MEM_RD_LAT-1];
    assign wr_en     = wr_sr_q[LAT-1];
    assign wr_addr_a = wa_sr_q[LAT-1];
    assign wr_addr_b = wb_sr_q[LAT-1];
endmodule

// File: tb/tb_fft16_bf_sequencer.sv
// Bench for fft16_bf_sequencer: schedule model derived from cycle arithmetic,
// plus a read-after-write scoreboard; default and (2,0) latency instances.
module tb_fft16_bf_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1 = 1'b1, start1 = 1'b0, rst2 = 1'b1, start2 = 1'b0;
    logic busy1, done1, rd1, bv1, wr1, busy2, done2, rd2, bv2, wr2;
    logic [1:0] st1, st2;
    logic [3:0] ra1, rb1, wa1, wb1, ra2, rb2, wa2, wb2;
    logic [2:0] tw1, tw2;

    fft16_bf_sequencer #(.MEM_RD_LAT(1), .BF_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1), .stage(st1),
        .rd_en(rd1), .rd_addr_a(ra1), .rd_addr_b(rb1), .bf_valid(bv1), .tw_idx(tw1),
        .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1));

    fft16_bf_sequencer #(.MEM_RD_LAT(2), .BF_LATENCY(0)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2), .stage(st2),
        .rd_en(rd2), .rd_addr_a(ra2), .rd_addr_b(rb2), .bf_valid(bv2), .tw_idx(tw2),
        .wr_en(wr2), .wr_addr_a(wa2), .wr_addr_b(wb2));

    int checks = 0, errors = 0;
    int sel, mrl, lat, P, DT, t, cyc;
    logic       e_rd [0:2047];
    logic [3:0] e_a  [0:2047];
    logic [3:0] e_b  [0:2047];
    logic [2:0] e_tw [0:2047];
    int wr_cnt [16];
    int rd_pulses, busy_cnt, done_cyc, wr_pulses, t0;

    logic o_busy, o_done, o_rd, o_bv, o_wr;
    logic [1:0] o_st;
    logic [3:0] o_ra, o_rb, o_wa, o_wb;
    logic [2:0] o_tw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic sample();
        if (sel == 0) begin
            o_busy = busy1; o_done = done1; o_st = st1; o_rd = rd1; o_ra = ra1; o_rb = rb1;
            o_bv = bv1; o_tw = tw1; o_wr = wr1; o_wa = wa1; o_wb = wb1;
        end else begin
            o_busy = busy2; o_done = done2; o_st = st2; o_rd = rd2; o_ra = ra2; o_rb = rb2;
            o_bv = bv2; o_tw = tw2; o_wr = wr2; o_wa = wa2; o_wb = wb2;
        end
    endtask

    task automatic clear_model();
        t = 0;
        for (int i = 0; i < 2048; i++) begin
            e_rd[i] = 1'b0; e_a[i] = '0; e_b[i] = '0; e_tw[i] = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        sample();
        chk({tag, "_busy"}, o_busy, 0);  chk({tag, "_done"}, o_done, 0);
        chk({tag, "_stage"}, o_st, 0);   chk({tag, "_rd_en"}, o_rd, 0);
        chk({tag, "_rd_a"}, o_ra, 0);    chk({tag, "_rd_b"}, o_rb, 0);
        chk({tag, "_bf_valid"}, o_bv, 0); chk({tag, "_tw"}, o_tw, 0);
        chk({tag, "_wr_en"}, o_wr, 0);   chk({tag, "_wr_a"}, o_wa, 0);
        chk({tag, "_wr_b"}, o_wb, 0);
    endtask

    task automatic predict_and_check();
        int s, k, half, j, e_st;
        logic e_busy, e_done, e_bv, e_wr;
        e_rd[cyc] = 1'b0;
        e_busy = (t >= 1) && (t < DT);
        e_done = (t == DT);
        e_st   = e_busy ? (t - 1) / P : (e_done ? 3 : 0);
        if (e_busy && ((t - 1) % P) < 8) begin
            s = (t - 1) / P;
            k = (t - 1) % P;
            half = 8 >> s;
            j = k % half;
            e_rd[cyc] = 1'b1;
            e_a[cyc]  = 4'(2 * half * (k / half) + j);
            e_b[cyc]  = 4'(2 * half * (k / half) + j + half);
            e_tw[cyc] = 3'((j << s) % 8);
        end
        e_bv = e_rd[cyc - mrl];
        e_wr = e_rd[cyc - lat];
        sample();
        chk("busy", o_busy, e_busy);
        chk("done", o_done, e_done);
        chk("stage", o_st, e_st);
        chk("rd_en", o_rd, e_rd[cyc]);
        chk("bf_valid", o_bv, e_bv);
        chk("wr_en", o_wr, e_wr);
        if (e_rd[cyc]) begin
            chk("rd_addr_a", o_ra, e_a[cyc]);
            chk("rd_addr_b", o_rb, e_b[cyc]);
        end
        if (e_bv) chk("tw_idx", o_tw, e_tw[cyc - mrl]);
        if (e_wr) begin
            chk("wr_addr_a", o_wa, e_a[cyc - lat]);
            chk("wr_addr_b", o_wb, e_b[cyc - lat]);
        end
        if (o_rd === 1'b1) begin
            chk("raw_order_a", wr_cnt[o_ra], e_st);
            chk("raw_order_b", wr_cnt[o_rb], e_st);
            rd_pulses++;
        end
        if (o_wr === 1'b1) begin
            wr_cnt[o_wa]++;
            wr_cnt[o_wb]++;
            wr_pulses++;
        end
        if (o_busy === 1'b1) busy_cnt++;
        if (o_done === 1'b1) done_cyc = cyc;
    endtask

    task automatic step(input logic st);
        int tn;
        if (sel == 0) start1 = st; else start2 = st;
        if (((t == 0) || (t == DT)) && st) tn = 1;
        else if ((t >= 1) && (t < DT)) tn = t + 1;
        else tn = 0;
        if (tn == 1) for (int a = 0; a < 16; a++) wr_cnt[a] = 0;
        @(posedge clk); #1;
        cyc++;
        t = tn;
        predict_and_check();
    endtask

    task automatic run_once(input int exp_done, input int exp_busy);
        repeat ($urandom_range(1, 5)) step(1'b0);
        rd_pulses = 0; busy_cnt = 0; done_cyc = -1; t0 = cyc;
        step(1'b1);
        for (int i = 0; i < 80 && t != 0; i++)
            step((t >= 1 && t < DT) ? ($urandom_range(0, 5) == 0) : 1'b0);
        chk("run_finished", t, 0);
        chk("rd_pulse_count", rd_pulses, 32);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("done_cycle", done_cyc - t0, exp_done);
        repeat (3) step(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 16; sel = 0; mrl = 1; lat = 3; P = 11; DT = 45;
        clear_model();
        for (int a = 0; a < 16; a++) wr_cnt[a] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        #2 rst1 = 1'b0;
        repeat (10) step(1'b0);

        run_once(45, 44);

        // start held high: one transform then restart straight from the done cycle
        done_cyc = -1; t0 = cyc;
        for (int i = 0; i < DT + 3; i++) step(1'b1);
        chk("held_done_cycle", done_cyc - t0, 45);
        for (int i = 0; i < 60 && t != 2 * P + 4; i++) step(1'b0);
        chk("reached_stage2_k3", t, 2 * P + 4);

        #2 rst1 = 1'b1;
        #1 check_all_zero("async_rst");
        clear_model();
        wr_pulses = 0;
        step(1'b0);
        #2 rst1 = 1'b0;
        repeat (12) step(1'b0);
        chk("wr_after_reset", wr_pulses, 0);
        run_once(45, 44);

        sel = 1; mrl = 2; lat = 2; P = 10; DT = 41;
        clear_model();
        #1;
        check_all_zero("dut2_reset");
        #1 rst2 = 1'b0;
        run_once(41, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
